// File: rtl/byteswap_sched_pkg.sv
// ============================================================================
// byteswap_sched_pkg
// Shared types for the byteswap job scheduler: FSM states, status codes, descriptor.
// Revision: 1.0
// ============================================================================
`default_nettype none

package byteswap_sched_pkg;

  // Widest descriptor fields carried through the queue; scheduler widths must not exceed these.
  localparam int SCHED_ADDR_W  = 64;
  localparam int SCHED_BYTES_W = 32;
  localparam int SCHED_TAG_W   = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    LAUNCH   = 3'd2,
    WAIT     = 3'd3,
    COMPLETE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OK           = 2'd0,
    SKIPPED_ZERO = 2'd1,
    ERR_ALIGN    = 2'd2
  } cmp_status_t;

  typedef struct packed {
    logic [SCHED_ADDR_W-1:0]  addr;
    logic [SCHED_BYTES_W-1:0] bytes;
    logic [SCHED_TAG_W-1:0]   tag;
  } desc_t;

endpackage

`default_nettype wire

// File: rtl/byteswap_job_scheduler_if.sv
// ============================================================================
// byteswap_job_scheduler_if
// Descriptor, datapath-launch and completion signals of the job scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface byteswap_job_scheduler_if #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_TAG_WIDTH       = 8
);
  logic                         desc_valid;
  logic                         desc_ready;
  logic [C_ADDR_WIDTH-1:0]      desc_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] desc_bytes;
  logic [C_TAG_WIDTH-1:0]       desc_tag;
  logic                         dp_start;
  logic [C_ADDR_WIDTH-1:0]      dp_addr;
  logic [C_XFER_SIZE_WIDTH-1:0] dp_bytes;
  logic                         dp_read_done;
  logic                         dp_write_done;
  logic                         cmp_valid;
  logic                         cmp_ready;
  logic [C_TAG_WIDTH-1:0]       cmp_tag;
  logic [1:0]                   cmp_status;
  logic                         busy;
  logic [31:0]                  jobs_done;

  // Scheduler side
  modport slave (
    input  desc_valid, desc_addr, desc_bytes, desc_tag,
    input  dp_read_done, dp_write_done, cmp_ready,
    output desc_ready, dp_start, dp_addr, dp_bytes,
    output cmp_valid, cmp_tag, cmp_status, busy, jobs_done
  );

  // Host / datapath side
  modport master (
    output desc_valid, desc_addr, desc_bytes, desc_tag,
    output dp_read_done, dp_write_done, cmp_ready,
    input  desc_ready, dp_start, dp_addr, dp_bytes,
    input  cmp_valid, cmp_tag, cmp_status, busy, jobs_done
  );
endinterface

`default_nettype wire

// File: rtl/byteswap_desc_fifo.sv
// ============================================================================
// byteswap_desc_fifo
// Synchronous FIFO with count-based full/empty; DEPTH must be a power of two >= 2.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byteswap_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  wire logic             ap_clk,
  input  wire logic             areset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wr_data,
  output logic                  full,
  input  wire logic             pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_en   = push && !full;
  assign rd_en   = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
    count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/byteswap_job_scheduler.sv
// ============================================================================
// byteswap_job_scheduler
// Queues byteswap descriptors, launches them one at a time, returns one completion each.
// Revision: 1.0
// ============================================================================
`default_nettype none

module byteswap_job_scheduler
  import byteswap_sched_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_TAG_WIDTH       = 8,
  parameter int C_QUEUE_DEPTH     = 4,
  parameter int C_DW_BYTES        = 64
) (
  input  wire logic               ap_clk,
  input  wire logic               areset,
  byteswap_job_scheduler_if.slave bus
);
  localparam logic [C_ADDR_WIDTH-1:0]      ADDR_MASK  = C_ADDR_WIDTH'(C_DW_BYTES - 1);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] BYTES_MASK = C_XFER_SIZE_WIDTH'(C_DW_BYTES - 1);

  desc_t push_desc;
  desc_t head_desc;
  logic  fifo_full;
  logic  fifo_empty;
  logic  fifo_push;
  logic  fifo_pop;

  state_t                       state_q, state_d;
  logic                         dp_start_q, dp_start_d;
  logic [C_ADDR_WIDTH-1:0]      dp_addr_q, dp_addr_d;
  logic [C_XFER_SIZE_WIDTH-1:0] dp_bytes_q, dp_bytes_d;
  logic [C_TAG_WIDTH-1:0]       job_tag_q, job_tag_d;
  logic                         rd_seen_q, rd_seen_d;
  logic                         wr_seen_q, wr_seen_d;
  logic                         cmp_valid_q, cmp_valid_d;
  logic [C_TAG_WIDTH-1:0]       cmp_tag_q, cmp_tag_d;
  cmp_status_t                  cmp_status_q, cmp_status_d;
  logic [31:0]                  jobs_done_q, jobs_done_d;
  logic                         rd_now;
  logic                         wr_now;

  // Held low through reset so nothing is offered into a queue that is being flushed
  assign bus.desc_ready = !fifo_full && !areset;
  assign fifo_push      = bus.desc_valid && bus.desc_ready;

  always_comb begin
    push_desc       = '0;
    push_desc.addr  = SCHED_ADDR_W'(bus.desc_addr);
    push_desc.bytes = SCHED_BYTES_W'(bus.desc_bytes);
    push_desc.tag   = SCHED_TAG_W'(bus.desc_tag);
  end

  byteswap_desc_fifo #(
    .DEPTH (C_QUEUE_DEPTH),
    .WIDTH ($bits(desc_t))
  ) u_desc_fifo (
    .ap_clk  (ap_clk),
    .areset  (areset),
    .push    (fifo_push),
    .wr_data (push_desc),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .rd_data (head_desc),
    .empty   (fifo_empty)
  );

  assign rd_now = rd_seen_q || bus.dp_read_done;
  assign wr_now = wr_seen_q || bus.dp_write_done;

  always_comb begin
    state_d      = state_q;
    dp_start_d   = 1'b0;
    dp_addr_d    = dp_addr_q;
    dp_bytes_d   = dp_bytes_q;
    job_tag_d    = job_tag_q;
    rd_seen_d    = rd_seen_q;
    wr_seen_d    = wr_seen_q;
    cmp_valid_d  = cmp_valid_q;
    cmp_tag_d    = cmp_tag_q;
    cmp_status_d = cmp_status_q;
    jobs_done_d  = jobs_done_q;
    fifo_pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          dp_addr_d  = C_ADDR_WIDTH'(head_desc.addr);
          dp_bytes_d = C_XFER_SIZE_WIDTH'(head_desc.bytes);
          job_tag_d  = C_TAG_WIDTH'(head_desc.tag);
          state_d    = CHECK;
        end
      end
      CHECK: begin
        if (dp_bytes_q == '0) begin
          cmp_status_d = SKIPPED_ZERO;
          cmp_tag_d    = job_tag_q;
          cmp_valid_d  = 1'b1;
          state_d      = COMPLETE;
        end else if (((dp_addr_q & ADDR_MASK) != '0) || ((dp_bytes_q & BYTES_MASK) != '0)) begin
          cmp_status_d = ERR_ALIGN;
          cmp_tag_d    = job_tag_q;
          cmp_valid_d  = 1'b1;
          state_d      = COMPLETE;
        end else begin
          dp_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        rd_seen_d = 1'b0;
        wr_seen_d = 1'b0;
        state_d   = WAIT;
      end
      WAIT: begin
        rd_seen_d = rd_now;
        wr_seen_d = wr_now;
        // The later of the two done pulses completes the job in the cycle it arrives
        if (rd_now && wr_now) begin
          cmp_status_d = OK;
          cmp_tag_d    = job_tag_q;
          cmp_valid_d  = 1'b1;
          state_d      = COMPLETE;
        end
      end
      COMPLETE: begin
        if (bus.cmp_ready) begin
          cmp_valid_d = 1'b0;
          jobs_done_d = jobs_done_q + 32'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q      <= IDLE;
      dp_start_q   <= 1'b0;
      dp_addr_q    <= '0;
      dp_bytes_q   <= '0;
      job_tag_q    <= '0;
      rd_seen_q    <= 1'b0;
      wr_seen_q    <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_tag_q    <= '0;
      cmp_status_q <= OK;
      jobs_done_q  <= '0;
    end else begin
      state_q      <= state_d;
      dp_start_q   <= dp_start_d;
      dp_addr_q    <= dp_addr_d;
      dp_bytes_q   <= dp_bytes_d;
      job_tag_q    <= job_tag_d;
      rd_seen_q    <= rd_seen_d;
      wr_seen_q    <= wr_seen_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_tag_q    <= cmp_tag_d;
      cmp_status_q <= cmp_status_d;
      jobs_done_q  <= jobs_done_d;
    end
  end

  assign bus.dp_start   = dp_start_q;
  assign bus.dp_addr    = dp_addr_q;
  assign bus.dp_bytes   = dp_bytes_q;
  assign bus.cmp_valid  = cmp_valid_q;
  assign bus.cmp_tag    = cmp_tag_q;
  assign bus.cmp_status = cmp_status_q;
  assign bus.jobs_done  = jobs_done_q;
  assign bus.busy       = (state_q != IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_byteswap_job_scheduler.sv
// ============================================================================
// tb_byteswap_job_scheduler
// Directed scenarios for the byteswap job scheduler with hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_byteswap_job_scheduler;
  logic ap_clk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   passed = 0;

  always #5 ap_clk = ~ap_clk;

  byteswap_job_scheduler_if #(.C_ADDR_WIDTH(64), .C_XFER_SIZE_WIDTH(32), .C_TAG_WIDTH(8)) bus ();

  byteswap_job_scheduler #(
    .C_ADDR_WIDTH(64), .C_XFER_SIZE_WIDTH(32), .C_TAG_WIDTH(8),
    .C_QUEUE_DEPTH(4), .C_DW_BYTES(64)
  ) dut (
    .ap_clk (ap_clk),
    .areset (areset),
    .bus    (bus)
  );

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] b, input logic [7:0] t);
    bus.desc_valid = 1'b1;
    bus.desc_addr  = a;
    bus.desc_bytes = b;
    bus.desc_tag   = t;
    step();
    bus.desc_valid = 1'b0;
  endtask

  task automatic pulse(input logic rd, input logic wr);
    bus.dp_read_done  = rd;
    bus.dp_write_done = wr;
    step();
    bus.dp_read_done  = 1'b0;
    bus.dp_write_done = 1'b0;
  endtask

  task automatic handshake();
    bus.cmp_ready = 1'b1;
    step();
    bus.cmp_ready = 1'b0;
  endtask

  // Returns in the cycle where dp_start is high, or gives up after 20 cycles
  task automatic wait_start(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus.dp_start === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.desc_ready !== 1'b0) $display("FAIL rst_ready_in_reset got=%0b exp=0", bus.desc_ready); else passed++;
    step(); step();
    checks++; if (bus.dp_start !== 1'b0 || bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rst_ctrl got start=%0b cmp=%0b busy=%0b exp 0/0/0", bus.dp_start, bus.cmp_valid, bus.busy); else passed++;
    checks++; if (bus.dp_addr !== 64'd0 || bus.dp_bytes !== 32'd0 || bus.cmp_tag !== 8'd0 || bus.cmp_status !== 2'd0 || bus.jobs_done !== 32'd0)
      $display("FAIL rst_data got addr=%0h bytes=%0h tag=%0h st=%0d jobs=%0d exp all 0", bus.dp_addr, bus.dp_bytes, bus.cmp_tag, bus.cmp_status, bus.jobs_done); else passed++;
    areset = 1'b0;
    step();
    checks++; if (bus.desc_ready !== 1'b1) $display("FAIL rst_ready_after got=%0b exp=1", bus.desc_ready); else passed++;
  endtask

  task automatic test_single_job();
    int bad;
    push(64'h1000, 32'd4096, 8'h5A);
    checks++; if (bus.dp_start !== 1'b0) $display("FAIL single_start_n1 got=%0b exp=0", bus.dp_start); else passed++;
    step();
    checks++; if (bus.dp_start !== 1'b0 || bus.dp_addr !== 64'h1000 || bus.dp_bytes !== 32'd4096 || bus.busy !== 1'b1)
      $display("FAIL single_check_cycle got start=%0b addr=%0h bytes=%0d busy=%0b exp 0/1000/4096/1", bus.dp_start, bus.dp_addr, bus.dp_bytes, bus.busy); else passed++;
    step();
    checks++; if (bus.dp_start !== 1'b1) $display("FAIL single_start_n3 got=%0b exp=1", bus.dp_start); else passed++;
    step();
    checks++; if (bus.dp_start !== 1'b0) $display("FAIL single_start_one_cycle got=%0b exp=0", bus.dp_start); else passed++;
    step(); step();
    pulse(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (bus.cmp_valid !== 1'b0) bad++;
      step();
    end
    checks++; if (bad != 0) $display("FAIL single_early_cmp got=%0d cycles exp=0", bad); else passed++;
    pulse(1'b0, 1'b1);
    checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h5A || bus.cmp_status !== 2'd0 || bus.jobs_done !== 32'd0)
      $display("FAIL single_cmp got v=%0b tag=%0h st=%0d jobs=%0d exp 1/5a/0/0", bus.cmp_valid, bus.cmp_tag, bus.cmp_status, bus.jobs_done); else passed++;
    handshake();
    checks++; if (bus.cmp_valid !== 1'b0 || bus.jobs_done !== 32'd1 || bus.busy !== 1'b0)
      $display("FAIL single_after_hs got v=%0b jobs=%0d busy=%0b exp 0/1/0", bus.cmp_valid, bus.jobs_done, bus.busy); else passed++;
  endtask

  task automatic test_done_order();
    logic found;
    push(64'h2000, 32'd128, 8'h11);
    wait_start(found);
    checks++; if (found !== 1'b1) $display("FAIL order_start1 got=timeout exp=dp_start"); else passed++;
    step();
    pulse(1'b1, 1'b1);
    checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h11 || bus.cmp_status !== 2'd0)
      $display("FAIL order_same_cycle got v=%0b tag=%0h st=%0d exp 1/11/0", bus.cmp_valid, bus.cmp_tag, bus.cmp_status); else passed++;
    handshake();
    checks++; if (bus.jobs_done !== 32'd2) $display("FAIL order_jobs2 got=%0d exp=2", bus.jobs_done); else passed++;
    push(64'h3000, 32'd64, 8'h22);
    wait_start(found);
    checks++; if (found !== 1'b1) $display("FAIL order_start2 got=timeout exp=dp_start"); else passed++;
    pulse(1'b1, 1'b0);   // lands in LAUNCH: must be ignored
    pulse(1'b0, 1'b1);
    step(); step();
    checks++; if (bus.cmp_valid !== 1'b0) $display("FAIL order_single_done got v=%0b exp=0", bus.cmp_valid); else passed++;
    pulse(1'b1, 1'b0);
    checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h22 || bus.cmp_status !== 2'd0)
      $display("FAIL order_reversed got v=%0b tag=%0h st=%0d exp 1/22/0", bus.cmp_valid, bus.cmp_tag, bus.cmp_status); else passed++;
    handshake();
    checks++; if (bus.jobs_done !== 32'd3 || bus.cmp_valid !== 1'b0)
      $display("FAIL order_jobs3 got jobs=%0d v=%0b exp 3/0", bus.jobs_done, bus.cmp_valid); else passed++;
  endtask

  task automatic test_edge_status();
    logic [63:0] va [3] = '{64'h4000, 64'h1004, 64'h4000};
    logic [31:0] vb [3] = '{32'd0, 32'd64, 32'd100};
    logic [1:0]  vs [3] = '{2'd1, 2'd2, 2'd2};
    int starts;
    for (int i = 0; i < 3; i++) begin
      starts = 0;
      push(va[i], vb[i], 8'(8'h30 + i));
      if (bus.dp_start !== 1'b0) starts++;
      step();
      if (bus.dp_start !== 1'b0) starts++;
      step();
      if (bus.dp_start !== 1'b0) starts++;
      checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_status !== vs[i] || bus.cmp_tag !== 8'(8'h30 + i))
        $display("FAIL edge_status_%0d got v=%0b st=%0d tag=%0h exp 1/%0d/%0h", i, bus.cmp_valid, bus.cmp_status, bus.cmp_tag, vs[i], 8'h30 + i); else passed++;
      handshake();
      if (bus.dp_start !== 1'b0) starts++;
      checks++; if (starts != 0 || bus.jobs_done !== 32'(4 + i))
        $display("FAIL edge_nostart_%0d got starts=%0d jobs=%0d exp 0/%0d", i, starts, bus.jobs_done, 4 + i); else passed++;
    end
  endtask

  task automatic test_full_queue();
    int not_ready;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.desc_ready !== 1'b1) $display("FAIL full_ready_%0d got=%0b exp=1", i, bus.desc_ready); else passed++;
      push(64'h10000 + 64'(i) * 64'h1000, 32'd64, 8'(i));
    end
    not_ready = 0;
    bus.desc_valid = 1'b1;
    bus.desc_tag   = 8'h09;
    for (int i = 0; i < 3; i++) begin
      if (bus.desc_ready !== 1'b0) not_ready++;
      step();
    end
    bus.desc_valid = 1'b0;
    checks++; if (not_ready != 0 || bus.busy !== 1'b1)
      $display("FAIL full_ready_low got ready_cycles=%0d busy=%0b exp 0/1", not_ready, bus.busy); else passed++;
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b1);
      checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'(i))
        $display("FAIL full_order_%0d got v=%0b tag=%0h exp 1/%0h", i, bus.cmp_valid, bus.cmp_tag, i); else passed++;
      handshake();
      if (i < 4) begin
        checks++; if (bus.dp_start !== 1'b0) $display("FAIL full_gap_h1_%0d got=%0b exp=0", i, bus.dp_start); else passed++;
        step();
        step();
        checks++; if (bus.dp_start !== 1'b1) $display("FAIL full_gap_h3_%0d got=%0b exp=1", i, bus.dp_start); else passed++;
        step();
      end
    end
    step();
    checks++; if (bus.jobs_done !== 32'd11 || bus.busy !== 1'b0 || bus.cmp_valid !== 1'b0)
      $display("FAIL full_drained got jobs=%0d busy=%0b v=%0b exp 11/0/0", bus.jobs_done, bus.busy, bus.cmp_valid); else passed++;
  endtask

  task automatic test_backpressure();
    int bad;
    push(64'h5000, 32'd192, 8'h77);
    push(64'h6000, 32'd64, 8'h78);
    step();
    checks++; if (bus.dp_start !== 1'b1) $display("FAIL bp_start got=%0b exp=1", bus.dp_start); else passed++;
    step();
    pulse(1'b1, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h77 || bus.cmp_status !== 2'd0 || bus.dp_start !== 1'b0 || bus.jobs_done !== 32'd11) bad++;
      step();
    end
    checks++; if (bad != 0) $display("FAIL bp_stable got bad_cycles=%0d exp=0", bad); else passed++;
    handshake();
    checks++; if (bus.jobs_done !== 32'd12) $display("FAIL bp_jobs12 got=%0d exp=12", bus.jobs_done); else passed++;
    step(); step();
    checks++; if (bus.dp_start !== 1'b1 || bus.dp_addr !== 64'h6000)
      $display("FAIL bp_next_start got start=%0b addr=%0h exp 1/6000", bus.dp_start, bus.dp_addr); else passed++;
    step();
    pulse(1'b1, 1'b1);
    checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h78)
      $display("FAIL bp_second got v=%0b tag=%0h exp 1/78", bus.cmp_valid, bus.cmp_tag); else passed++;
    handshake();
    checks++; if (bus.jobs_done !== 32'd13) $display("FAIL bp_jobs13 got=%0d exp=13", bus.jobs_done); else passed++;
  endtask

  task automatic test_reset_mid_job();
    logic found;
    int   bad;
    push(64'h7000, 32'd64, 8'hA0);
    wait_start(found);
    checks++; if (found !== 1'b1) $display("FAIL rmid_start got=timeout exp=dp_start"); else passed++;
    push(64'h8000, 32'd64, 8'hA1);
    push(64'h9000, 32'd64, 8'hA2);
    areset = 1'b1;
    #1;
    checks++; if (bus.desc_ready !== 1'b0) $display("FAIL rmid_ready_in_reset got=%0b exp=0", bus.desc_ready); else passed++;
    step();
    checks++; if (bus.dp_start !== 1'b0 || bus.cmp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.jobs_done !== 32'd0 ||
                  bus.dp_addr !== 64'd0 || bus.dp_bytes !== 32'd0 || bus.cmp_tag !== 8'd0 || bus.cmp_status !== 2'd0)
      $display("FAIL rmid_values got start=%0b v=%0b busy=%0b jobs=%0d addr=%0h bytes=%0d tag=%0h st=%0d exp all 0",
               bus.dp_start, bus.cmp_valid, bus.busy, bus.jobs_done, bus.dp_addr, bus.dp_bytes, bus.cmp_tag, bus.cmp_status); else passed++;
    areset = 1'b0;
    #1;
    checks++; if (bus.desc_ready !== 1'b1) $display("FAIL rmid_ready_after got=%0b exp=1", bus.desc_ready); else passed++;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.cmp_valid !== 1'b0 || bus.dp_start !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL rmid_flushed got bad_cycles=%0d exp=0", bad); else passed++;
    push(64'hA000, 32'd256, 8'h3C);
    step(); step();
    checks++; if (bus.dp_start !== 1'b1 || bus.dp_addr !== 64'hA000 || bus.dp_bytes !== 32'd256)
      $display("FAIL rmid_new_start got start=%0b addr=%0h bytes=%0d exp 1/a000/256", bus.dp_start, bus.dp_addr, bus.dp_bytes); else passed++;
    step();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    checks++; if (bus.cmp_valid !== 1'b1 || bus.cmp_tag !== 8'h3C || bus.cmp_status !== 2'd0)
      $display("FAIL rmid_new_cmp got v=%0b tag=%0h st=%0d exp 1/3c/0", bus.cmp_valid, bus.cmp_tag, bus.cmp_status); else passed++;
    handshake();
    checks++; if (bus.jobs_done !== 32'd1) $display("FAIL rmid_jobs got=%0d exp=1", bus.jobs_done); else passed++;
  endtask

  initial begin
    bus.desc_valid    = 1'b0;
    bus.desc_addr     = '0;
    bus.desc_bytes    = '0;
    bus.desc_tag      = '0;
    bus.dp_read_done  = 1'b0;
    bus.dp_write_done = 1'b0;
    bus.cmp_ready     = 1'b0;
    test_reset();
    test_single_job();
    test_done_order();
    test_edge_status();
    test_full_queue();
    test_backpressure();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
